ws2812_chain: RTL and testbench
===============================

Name: ws2812_chain

Overview:
- Parametrised successor to the single-output WS2812 driver.
- Holds an on-chip pixel buffer of NUM_LEDS 24-bit colours, written through a random-access port.
- Serialises the whole buffer to one WS2812 data line with derived bit timing, then the latch/reset gap.
- Adds a start/busy/frame_done handshake and an auto-refresh mode; sits in a harness project slot behind IO pins.

Parameters:
NUM_LEDS, 8, number of pixels in buffer/chain (1..256)
CLK_HZ, 12000000, clk frequency in Hz
T0H_NS, 350, high time of a 0 bit in ns
T1H_NS, 700, high time of a 1 bit in ns
BIT_NS, 1250, total bit period in ns
RESET_US, 50, low latch gap after frame in us

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rgb_data  input  24  pixel colour {R[23:16],G[15:8],B[7:0]}
led_num  input  8  pixel index for write
write  input  1  store rgb_data at led_num this cycle
start  input  1  request one frame transmission (level sampled per cycle)
auto_mode  input  1  1 = retransmit continuously after each frame
busy  output  1  frame or reset gap in progress
frame_done  output  1  one-cycle pulse at end of reset gap
data  output  1  WS2812 serial data line

Behaviour:
- Derived cycle counts (integer, truncating, 32-bit): T0H_CYC=(CLK_HZ/1000)*T0H_NS/1000000; T1H_CYC, BIT_CYC likewise; RST_CYC=(CLK_HZ/1000)*RESET_US/1000. Defaults give 4, 8, 15, 600.
- Reset (async, reset_n=0): data=0, busy=0, frame_done=0, FSM=IDLE, all counters 0, every buffer entry 0x000000.
- Write port: on an edge with write=1 and led_num<NUM_LEDS, buf[led_num]<=rgb_data. led_num>=NUM_LEDS is ignored. Writes are accepted in every state.
- FSM states: IDLE, SEND, GAP.
- IDLE -> SEND on an edge with start=1. On that edge: busy<=1, pixel index<=0, bit index<=0, cycle counter<=0, shift reg<=buf[0] (old value if written the same edge), data<=1.
- Wire order per pixel: G[7:0], R[7:0], B[7:0], MSB first. Pixels go in index order 0..NUM_LEDS-1.
- SEND, per bit: data=1 for TxH_CYC cycles (x = current bit value), then 0 for the rest of BIT_CYC.
- After the last cycle of bit 23, the next pixel is latched from the buffer at that edge (old value on a same-edge write) and its first bit's high phase starts immediately. There are no gaps between bits or pixels.
- Buffer updates made mid-frame to pixels not yet latched appear in this frame. Updates to the pixel being sent, or to earlier pixels, appear in the next frame.
- After the last bit of pixel NUM_LEDS-1: data=0 and GAP holds for RST_CYC cycles.
- End of GAP: frame_done=1 for exactly one cycle.
  - If auto_mode=1 on that edge: start the next frame as the IDLE->SEND edge does; busy stays 1.
  - Otherwise: go to IDLE and drop busy on the same edge.
- Busy duration per frame: NUM_LEDS*24*BIT_CYC + RST_CYC cycles.
- start while busy=1 is ignored and is not queued.
- start=1 held high in IDLE with auto_mode=0 starts a new frame on the first edge after returning to IDLE.
- auto_mode deasserted mid-frame: the current frame completes, then the block returns to IDLE.
- reset_n asserted mid-frame: data drops to 0 immediately (async), the buffer clears, and no frame_done is produced.

Test Plan:
- Default params, write led 0 = 0x00FF00 (G=0xFF), pulse start -> data shows 8 bits high 8/low 7 cycles, then 16 bits high 4/low 11 cycles. Other pixels are all 0-bits. busy high for 8*24*15+600=3480 cycles. frame_done pulses once, busy falls with it.
- Write led_num=8 with 0xFFFFFF after clearing -> next frame all bits are 0-pattern (4 high/11 low); out-of-range write has no effect.
- Pulse start again at cycle 1000 of a frame -> no restart; busy duration stays 3480 and exactly one frame_done.
- auto_mode=1, start once -> frame_done every 3480 cycles. busy never drops; the next frame's data rises on the cycle after frame_done. Clear auto_mode mid-frame -> that frame finishes, then IDLE.
- Mid-frame (during pixel 2): write led 5=0xFFFFFF and led 1=0xFFFFFF -> pixel 5 sent as all 1-bits (8/7) this frame; pixel 1 changes only in the next frame.
- Assert reset_n low at cycle 500 of a frame -> data=0, busy=0 immediately. After release, a start sends all-zero pixels (buffer cleared).

Source files
------------

// File: rtl/ws2812_chain.sv
// ws2812_chain
// Holds a buffer of NUM_LEDS 24-bit pixel colours, written through a
// random-access port. On request it serialises the whole buffer onto one
// WS2812 data line, then holds the line low for the latch gap. In auto mode
// the next frame follows the gap directly.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   rgb_data    pixel colour {R[23:16], G[15:8], B[7:0]}
//   led_num     pixel index for a write
//   write       store rgb_data at led_num on this edge
//   start       request one frame (ignored while busy)
//   auto_mode   retransmit continuously after each frame
//   busy        frame or latch gap in progress
//   frame_done  one-cycle pulse in the final cycle of the latch gap
//   data        WS2812 serial data line
module ws2812_chain #(
   parameter int NUM_LEDS = 8,
   parameter int CLK_HZ   = 12000000,
   parameter int T0H_NS   = 350,
   parameter int T1H_NS   = 700,
   parameter int BIT_NS   = 1250,
   parameter int RESET_US = 50
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [23:0] rgb_data,
   input  logic [7:0]  led_num,
   input  logic        write,
   input  logic        start,
   input  logic        auto_mode,
   output logic        busy,
   output logic        frame_done,
   output logic        data
);

   localparam int T0H_CYC = (CLK_HZ / 1000) * T0H_NS / 1000000;
   localparam int T1H_CYC = (CLK_HZ / 1000) * T1H_NS / 1000000;
   localparam int BIT_CYC = (CLK_HZ / 1000) * BIT_NS / 1000000;
   localparam int RST_CYC = (CLK_HZ / 1000) * RESET_US / 1000;

   localparam int CW = $clog2(BIT_CYC + 1);
   localparam int GW = $clog2(RST_CYC + 1);
   localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [CW-1:0] T0H_C     = CW'(T0H_CYC);
   localparam logic [CW-1:0] T1H_C     = CW'(T1H_CYC);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(RST_CYC - 1);
   localparam logic [PW-1:0] PIX_LAST  = PW'(NUM_LEDS - 1);
   localparam logic [8:0]    LED_LIMIT = 9'(NUM_LEDS);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t        state_q, state_d;
   logic [23:0]   pix_buf_q [NUM_LEDS];
   logic [23:0]   pix_buf_d [NUM_LEDS];
   logic [23:0]   shift_q, shift_d;
   logic [4:0]    bit_q, bit_d;
   logic [PW-1:0] pix_q, pix_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          data_q, data_d;

   logic          launch;
   logic [PW-1:0] pix_next;
   logic [CW-1:0] cyc_next;

   // Buffer stores {R,G,B}; the wire wants G, R, B, each MSB first.
   function automatic logic [23:0] to_wire(input logic [23:0] c);
      return {c[15:8], c[23:16], c[7:0]};
   endfunction

   always_comb begin
      state_d   = state_q;
      pix_buf_d = pix_buf_q;
      shift_d   = shift_q;
      bit_d     = bit_q;
      pix_d     = pix_q;
      cyc_d     = cyc_q;
      gap_d     = gap_q;
      busy_d    = busy_q;
      data_d    = data_q;
      launch    = 1'b0;
      pix_next  = pix_q + 1'b1;
      cyc_next  = cyc_q + 1'b1;

      if (write && ({1'b0, led_num} < LED_LIMIT)) begin
         pix_buf_d[led_num[PW-1:0]] = rgb_data;
      end

      case (state_q)
         IDLE: begin
            launch = start;
         end
         SEND: begin
            if (cyc_q == BIT_LAST) begin
               cyc_d = '0;
               if (bit_q == 5'd23) begin
                  bit_d = '0;
                  if (pix_q == PIX_LAST) begin
                     state_d = GAP;
                     gap_d   = '0;
                     data_d  = 1'b0;
                  end else begin
                     // Reads the pre-edge buffer, so a same-edge write is not seen here.
                     pix_d   = pix_next;
                     shift_d = to_wire(pix_buf_q[pix_next]);
                     data_d  = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 5'd1;
                  shift_d = {shift_q[22:0], 1'b0};
                  data_d  = 1'b1;
               end
            end else begin
               cyc_d  = cyc_next;
               data_d = (cyc_next < (shift_q[23] ? T1H_C : T0H_C));
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               if (auto_mode) begin
                  launch = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  data_d  = 1'b0;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            data_d  = 1'b0;
         end
      endcase

      if (launch) begin
         state_d = SEND;
         busy_d  = 1'b1;
         pix_d   = '0;
         bit_d   = '0;
         cyc_d   = '0;
         gap_d   = '0;
         shift_d = to_wire(pix_buf_q[0]);
         data_d  = 1'b1;
      end

      // Registered so the pulse sits exactly on the final gap cycle.
      done_d = (state_d == GAP) && (gap_d == GAP_LAST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         for (int i = 0; i < NUM_LEDS; i++) begin
            pix_buf_q[i] <= '0;
         end
         shift_q <= '0;
         bit_q   <= '0;
         pix_q   <= '0;
         cyc_q   <= '0;
         gap_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pix_buf_q <= pix_buf_d;
         shift_q   <= shift_d;
         bit_q     <= bit_d;
         pix_q     <= pix_d;
         cyc_q     <= cyc_d;
         gap_q     <= gap_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         data_q    <= data_d;
      end
   end

   assign busy       = busy_q;
   assign frame_done = done_q;
   assign data       = data_q;

endmodule

// File: tb/tb_ws2812_chain.sv
// Self-checking bench for ws2812_chain with default parameters.
// A monitor decodes the serial line into 24-bit wire words and compares each
// against expectations queued when a frame is requested.
module tb_ws2812_chain;

   localparam int NUM_LEDS = 8;
   localparam int T0H      = 4;
   localparam int T1H      = 8;
   localparam int BIT      = 15;
   localparam int RST      = 600;
   localparam int FRAME    = NUM_LEDS * 24 * BIT + RST;

   typedef struct {
      int          pix;
      logic [23:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [23:0] rgb_data = '0;
   logic [7:0]  led_num = '0;
   logic        write = 1'b0;
   logic        start = 1'b0;
   logic        auto_mode = 1'b0;
   logic        busy;
   logic        frame_done;
   logic        data;

   ws2812_chain dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rgb_data   (rgb_data),
      .led_num    (led_num),
      .write      (write),
      .start      (start),
      .auto_mode  (auto_mode),
      .busy       (busy),
      .frame_done (frame_done),
      .data       (data)
   );

   // Free-running clock and cycle counter used for timing checks.
   initial forever #5 clk = ~clk;

   int unsigned cycle = 0;
   initial forever begin
      @(posedge clk);
      cycle++;
   end

   int checks = 0;
   int passes = 0;

   logic [23:0] mdl [NUM_LEDS];
   exp_t        expQ[$];

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   function automatic logic [23:0] grb(input logic [23:0] c);
      return {c[15:8], c[23:16], c[7:0]};
   endfunction

   // Line decoder state.
   int          hiCnt = 0;
   int          loCnt = 0;
   int          bitIdx = 0;
   int          badBits = 0;
   logic [23:0] word = '0;
   int          busyRun = 0;
   int          lastBusyLen = 0;
   int          busyEnds = 0;
   int          doneCount = 0;

   // Closes one decoded bit; on the 24th bit compares the pixel with the queue head.
   task automatic finishBit();
      int   total;
      logic b;
      exp_t e;
      total = hiCnt + loCnt;
      b = (hiCnt >= (T0H + T1H) / 2);
      if (total != BIT || hiCnt != (b ? T1H : T0H)) badBits++;
      word = {word[22:0], b};
      bitIdx++;
      hiCnt = 0;
      loCnt = 0;
      if (bitIdx == 24) begin
         if (expQ.size() == 0) begin
            checkOutput("extraPixel", 32'(word), 32'hDEAD_BEEF);
         end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("pixel%0d", e.pix), 32'(word), 32'(e.val));
         end
         checkOutput("bitTiming", badBits, 0);
         bitIdx  = 0;
         badBits = 0;
      end
   endtask

   // Monitor: samples on the falling edge, away from the DUT's active edge.
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         hiCnt = 0; loCnt = 0; bitIdx = 0; badBits = 0; word = '0; busyRun = 0;
      end else begin
         if (busy) busyRun++;
         else if (busyRun > 0) begin
            lastBusyLen = busyRun;
            busyRun = 0;
            busyEnds++;
         end
         if (frame_done) begin
            doneCount++;
            checkOutput("busyAtDone", 32'(busy), 1);
         end
         if (data) begin
            if (loCnt > 0) finishBit();
            hiCnt++;
         end else if (hiCnt > 0) begin
            loCnt++;
         end
         if (hiCnt > 0 && hiCnt + loCnt == BIT) finishBit();
      end
   end

   // Drives one cycle of port activity, then returns the strobes low.
   task automatic applyStimulus(input logic wr, input logic [7:0] idx, input logic [23:0] rgb, input logic st);
      @(negedge clk);
      write = wr; led_num = idx; rgb_data = rgb; start = st;
      @(negedge clk);
      write = 1'b0; start = 1'b0;
   endtask

   task automatic writePixel(input int idx, input logic [23:0] rgb);
      applyStimulus(1'b1, 8'(idx), rgb, 1'b0);
      if (idx < NUM_LEDS) mdl[idx] = rgb;
   endtask

   task automatic pushFrame();
      exp_t e;
      for (int i = 0; i < NUM_LEDS; i++) begin
         e.pix = i;
         e.val = grb(mdl[i]);
         expQ.push_back(e);
      end
   endtask

   task automatic waitBusyLow(input int bound);
      int n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput("busyTimeout", 1, 0);
      @(negedge clk);
   endtask

   task automatic waitDone(input int bound, output int at);
      int n = 0;
      @(negedge clk);
      while (!frame_done && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!frame_done) checkOutput("doneTimeout", 0, 1);
      at = int'(cycle);
   endtask

   // One full frame; optional extra start pulse partway through.
   task automatic runFrame(input int restartAt);
      int d0;
      d0 = doneCount;
      pushFrame();
      applyStimulus(1'b0, 8'd0, 24'd0, 1'b1);
      if (restartAt > 0) begin
         repeat (restartAt) @(negedge clk);
         applyStimulus(1'b0, 8'd0, 24'd0, 1'b1);
      end
      waitBusyLow(FRAME + 100);
      checkOutput("busyLen", lastBusyLen, FRAME);
      checkOutput("doneCount", doneCount - d0, 1);
      checkOutput("pixelsLeft", expQ.size(), 0);
   endtask

   task automatic autoTest();
      int d0, e0, t1, t2;
      d0 = doneCount;
      e0 = busyEnds;
      auto_mode = 1'b1;
      pushFrame(); pushFrame(); pushFrame();
      applyStimulus(1'b0, 8'd0, 24'd0, 1'b1);
      waitDone(FRAME + 100, t1);
      @(negedge clk);
      checkOutput("autoDataRise", 32'(data), 1);
      checkOutput("autoBusy", 32'(busy), 1);
      waitDone(FRAME + 100, t2);
      checkOutput("autoPeriod", t2 - t1, FRAME);
      repeat (1000) @(negedge clk);
      auto_mode = 1'b0;
      waitBusyLow(2 * FRAME);
      checkOutput("autoDoneCount", doneCount - d0, 3);
      checkOutput("autoBusyEnds", busyEnds - e0, 1);
      checkOutput("autoBusyLen", lastBusyLen, 3 * FRAME);
      checkOutput("autoPixelsLeft", expQ.size(), 0);
   endtask

   task automatic midFrameTest();
      for (int i = 0; i < NUM_LEDS; i++) writePixel(i, 24'h000000);
      pushFrame();
      applyStimulus(1'b0, 8'd0, 24'd0, 1'b1);
      // Pixel 2 occupies frame cycles 720..1079.
      repeat (800) @(negedge clk);
      writePixel(5, 24'hFFFFFF);
      writePixel(1, 24'hFFFFFF);
      foreach (expQ[k]) if (expQ[k].pix == 5) expQ[k].val = grb(24'hFFFFFF);
      waitBusyLow(FRAME + 100);
      checkOutput("midBusyLen", lastBusyLen, FRAME);
      checkOutput("midPixelsLeft", expQ.size(), 0);
      runFrame(0);
   endtask

   task automatic resetTest();
      int d0, n;
      pushFrame();
      applyStimulus(1'b0, 8'd0, 24'd0, 1'b1);
      repeat (500) @(negedge clk);
      n = 0;
      while (!data && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("dataHighBeforeReset", 32'(data), 1);
      d0 = doneCount;
      #1 reset_n = 1'b0;
      #1;
      checkOutput("resetData", 32'(data), 0);
      checkOutput("resetBusy", 32'(busy), 0);
      expQ.delete();
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < NUM_LEDS; i++) mdl[i] = '0;
      repeat (100) @(negedge clk);
      checkOutput("noDoneAfterReset", doneCount - d0, 0);
      checkOutput("idleAfterReset", 32'(busy), 0);
      runFrame(0);
   endtask

   initial begin
      for (int i = 0; i < NUM_LEDS; i++) mdl[i] = '0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rstData", 32'(data), 0);
      checkOutput("rstBusy", 32'(busy), 0);
      checkOutput("rstDone", 32'(frame_done), 0);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] single green pixel frame");
      writePixel(0, 24'h00FF00);
      runFrame(0);

      $display("[TB] cleared buffer with out-of-range writes");
      writePixel(0, 24'h000000);
      writePixel(8, 24'hFFFFFF);
      writePixel(255, 24'hFFFFFF);
      runFrame(0);

      $display("[TB] start while busy is ignored");
      writePixel(2, 24'hA5C30F);
      runFrame(1000);

      $display("[TB] auto mode");
      writePixel(3, 24'h123456);
      autoTest();

      $display("[TB] mid-frame buffer updates");
      midFrameTest();

      $display("[TB] reset mid-frame");
      resetTest();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
